prog_loader: RTL and testbench

Host-side program loader that writes the 18-bit instruction memory which the CPU fetch path reads. It accepts a framed byte stream over a valid/ready handshake and assembles 18-bit instruction words. It writes them to sequential addresses from 0 and holds the CPU halted until a complete, valid image is loaded. It sits between the host link (UART receiver or test bench) and the write port of the program RAM that replaces the ROM.

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader.sv | 139 +++++++++++++
 tb/tb_prog_loader.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, frame marker and widths.
package prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         ADDR_W    = 16;
    localparam int         INSTR_W   = 18;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        W0,
        W1,
        W2,
        WRITE,
        CSUM,
        DONE,
        ERR
    } loaderState_e;

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader for the 18-bit program RAM; holds the CPU until an image is loaded.
// Define PROG_LOADER_CHECKSUM_EN to expect and verify a trailing XOR checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = prog_loader_pkg::SYNC_BYTE,
    parameter int         ADDR_W    = prog_loader_pkg::ADDR_W,
    parameter int         INSTR_W   = prog_loader_pkg::INSTR_W
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic [0:7]         i_rxData,
    input  logic               i_rxValid,
    output logic               o_rxReady,
    output logic [0:ADDR_W-1]  o_wAddr,
    output logic [0:INSTR_W-1] o_wData,
    output logic               o_wEn,
    output logic               o_cpuHold,
    output logic               o_done,
    output logic               o_error
);

    // Bit 0 of the port is the MSB, so a plain copy gives a conventional [7:0] byte.
    logic [7:0]         rxByte;
    logic               accept;
    logic               isSync;
    loaderState_e       state;
    loaderState_e       stateNext;
    logic [ADDR_W-1:0]  lenN;
    logic [ADDR_W-1:0]  wAddr;
    logic [ADDR_W-1:0]  addrInc;
    logic [INSTR_W-1:0] wData;
    logic               lastWord;

    assign rxByte   = i_rxData;
    assign accept   = i_rxValid && o_rxReady;
    assign isSync   = (rxByte == SYNC_BYTE);
    assign addrInc  = wAddr + ADDR_W'(1);
    assign lastWord = (addrInc == lenN);
    assign o_wAddr  = wAddr;
    assign o_wData  = wData;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            csum <= 8'd0;
        end else if (accept) begin
            case (state)
                IDLE, DONE, ERR: if (isSync) csum <= 8'd0;
                LEN_HI, LEN_LO, W0, W1, W2: csum <= csum ^ rxByte;
                default: ;
            endcase
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= stateNext;
    end

    // NOTE: stateNext is defaulted first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE, ERR: if (accept && isSync) stateNext = LEN_HI;
            LEN_HI:          if (accept) stateNext = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (lenN[15:8] == 8'd0 && rxByte == 8'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        stateNext = CSUM;
`else
                        stateNext = DONE;
`endif
                    end else begin
                        stateNext = W0;
                    end
                end
            end
            W0:     if (accept) stateNext = (rxByte[7:2] != 6'd0) ? ERR : W1;
            W1:     if (accept) stateNext = W2;
            W2:     if (accept) stateNext = WRITE;
            WRITE: begin
                if (lastWord) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    stateNext = CSUM;
`else
                    stateNext = DONE;
`endif
                end else begin
                    stateNext = W0;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM:   if (accept) stateNext = (rxByte == csum) ? DONE : ERR;
`endif
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lenN      <= '0;
            wAddr     <= '0;
            wData     <= '0;
            o_rxReady <= 1'b1;
            o_wEn     <= 1'b0;
            o_cpuHold <= 1'b1;
            o_done    <= 1'b0;
            o_error   <= 1'b0;
        end else begin
            o_rxReady <= (stateNext != WRITE);
            o_wEn     <= (stateNext == WRITE);
            o_cpuHold <= (stateNext != DONE);
            o_done    <= (stateNext == DONE);
            o_error   <= (stateNext == ERR);

            if (state == WRITE) wAddr <= addrInc;

            if (accept) begin
                case (state)
                    IDLE, DONE, ERR: if (isSync) wAddr <= '0;
                    LEN_HI: lenN[15:8]   <= rxByte;
                    LEN_LO: lenN[7:0]    <= rxByte;
                    W0:     wData[17:16] <= rxByte[1:0];
                    W1:     wData[15:8]  <= rxByte;
                    W2:     wData[7:0]   <= rxByte;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frame table, reset-abort sequence, random frames vs a parser model.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [7:0]  rxData = 8'd0;
    logic        rxValid = 1'b0;
    logic        rxReady;
    logic [15:0] wAddr;
    logic [17:0] wData;
    logic        wEn;
    logic        cpuHold;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    prog_loader dut (
        .i_clock   (clk),
        .i_reset_n (rstN),
        .i_rxData  (rxData),
        .i_rxValid (rxValid),
        .o_rxReady (rxReady),
        .o_wAddr   (wAddr),
        .o_wData   (wData),
        .o_wEn     (wEn),
        .o_cpuHold (cpuHold),
        .o_done    (done),
        .o_error   (error)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write capture and ready/strobe consistency monitor.
    logic [15:0] wrAddrQ[$];
    logic [17:0] wrDataQ[$];
    int          readyBad = 0;

    always @(negedge clk) begin
        if (rstN) begin
            if (wEn) begin
                wrAddrQ.push_back(wAddr);
                wrDataQ.push_back(wData);
            end
            if (rxReady == wEn) readyBad++;
        end
    end

    task automatic doReset();
        rstN = 1'b0;
        rxValid = 1'b0;
        repeat (2) @(negedge clk);
        wrAddrQ.delete();
        wrDataQ.delete();
        rstN = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic sendByte(input logic [7:0] b, input int gap);
        int t;
        if (gap > 0) begin
            rxValid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rxData = b;
        rxValid = 1'b1;
        t = 0;
        while (!rxReady && t < 8) begin
            @(negedge clk);
            t++;
        end
        if (t >= 8) check("rx_ready_timeout", 32'(rxReady), 32'd1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rxValid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Reference parser over the whole byte stream since the last reset.
    logic [7:0]  streamQ[$];
    logic [15:0] expAddrQ[$];
    logic [17:0] expDataQ[$];
    int          expStatus;   // 0 = busy/idle, 1 = done, 2 = error

    task automatic runModel();
        int         i;
        int         n;
        int         sz;
        logic [7:0] cs;
        logic [7:0] b0;
        bit         ok;
        expAddrQ.delete();
        expDataQ.delete();
        expStatus = 0;
        sz = streamQ.size();
        i = 0;
        while (1) begin
            while (i < sz && streamQ[i] != SYNC_BYTE) i++;
            if (i >= sz) return;
            i++;
            expStatus = 0;
            if (i + 2 > sz) return;
            n  = {streamQ[i], streamQ[i+1]};
            cs = streamQ[i] ^ streamQ[i+1];
            i += 2;
            ok = 1'b1;
            for (int k = 0; k < n; k++) begin
                if (i >= sz) return;
                b0 = streamQ[i];
                if (b0 >= 8'd4) begin
                    ok = 1'b0;
                    i++;
                    break;
                end
                if (i + 3 > sz) return;
                expAddrQ.push_back(16'(k));
                expDataQ.push_back({b0[1:0], streamQ[i+1], streamQ[i+2]});
                cs ^= b0 ^ streamQ[i+1] ^ streamQ[i+2];
                i += 3;
            end
            if (!ok) begin
                expStatus = 2;
                continue;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            if (i >= sz) return;
            expStatus = (streamQ[i] == cs) ? 1 : 2;
            i++;
`else
            expStatus = 1;
`endif
        end
    endtask

    typedef struct packed {
        logic [0:11][7:0] bytes;
        logic [7:0]       len;
        logic [7:0]       settle;
        logic [7:0]       nWr;
        logic [17:0]      d0;
        logic [17:0]      d1;
        logic             expDone;
        logic             expErr;
    } vec_t;

    vec_t vecs[4];

    task automatic checkWrites(input string tag, input int nWr, input logic [17:0] d0, input logic [17:0] d1);
        check({tag, "_nwrites"}, 32'(wrDataQ.size()), 32'(nWr));
        if (nWr > 0 && wrDataQ.size() > 0) begin
            check({tag, "_addr0"}, 32'(wrAddrQ[0]), 32'd0);
            check({tag, "_data0"}, 32'(wrDataQ[0]), 32'(d0));
        end
        if (nWr > 1 && wrDataQ.size() > 1) begin
            check({tag, "_addr1"}, 32'(wrAddrQ[1]), 32'd1);
            check({tag, "_data1"}, 32'(wrDataQ[1]), 32'(d1));
        end
    endtask

    initial begin
`ifdef PROG_LOADER_CHECKSUM_EN
        vecs[0] = '{96'hA5_00_02_01_23_45_03_FF_FF_66_00_00, 8'd10, 8'd0, 8'd2, 18'h12345, 18'h3FFFF, 1'b1, 1'b0};
        vecs[1] = '{96'hA5_00_01_04_00_00_00_00_00_00_00_00, 8'd6,  8'd0, 8'd0, 18'h0,     18'h0,     1'b0, 1'b1};
        vecs[2] = '{96'hA5_00_01_00_00_01_01_00_00_00_00_00, 8'd7,  8'd0, 8'd1, 18'h00001, 18'h0,     1'b0, 1'b1};
        vecs[3] = '{96'h00_7F_A5_00_00_00_00_00_00_00_00_00, 8'd6,  8'd0, 8'd0, 18'h0,     18'h0,     1'b1, 1'b0};
`else
        vecs[0] = '{96'hA5_00_02_01_23_45_03_FF_FF_00_00_00, 8'd9,  8'd1, 8'd2, 18'h12345, 18'h3FFFF, 1'b1, 1'b0};
        vecs[1] = '{96'hA5_00_01_04_00_00_00_00_00_00_00_00, 8'd6,  8'd0, 8'd0, 18'h0,     18'h0,     1'b0, 1'b1};
        vecs[2] = '{96'hA5_00_01_00_00_01_00_00_00_00_00_00, 8'd6,  8'd1, 8'd1, 18'h00001, 18'h0,     1'b1, 1'b0};
        vecs[3] = '{96'h00_7F_A5_00_00_01_00_00_00_00_00_00, 8'd6,  8'd0, 8'd0, 18'h0,     18'h0,     1'b1, 1'b0};
`endif

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_rxready", 32'(rxReady), 32'd1);
        check("rst_wen",     32'(wEn),     32'd0);
        check("rst_waddr",   32'(wAddr),   32'd0);
        check("rst_wdata",   32'(wData),   32'd0);
        check("rst_hold",    32'(cpuHold), 32'd1);
        check("rst_done",    32'(done),    32'd0);
        check("rst_error",   32'(error),   32'd0);

        // Directed frames, bytes back to back with valid held high.
        for (int v = 0; v < 4; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            doReset();
            for (int j = 0; j < int'(vecs[v].len); j++) sendByte(vecs[v].bytes[j], 0);
            idle(int'(vecs[v].settle));
            check({tag, "_done"},  32'(done),    32'(vecs[v].expDone));
            check({tag, "_error"}, 32'(error),   32'(vecs[v].expErr));
            check({tag, "_hold"},  32'(cpuHold), 32'(!vecs[v].expDone));
            checkWrites(tag, int'(vecs[v].nWr), vecs[v].d0, vecs[v].d1);
        end

        // Reset while waiting for the third byte of the first word.
        doReset();
        sendByte(8'hA5, 0);
        sendByte(8'h00, 0);
        sendByte(8'h02, 0);
        sendByte(8'h01, 0);
        sendByte(8'h23, 0);
        rstN = 1'b0;
        rxValid = 1'b0;
        #1;
        check("abort_rxready", 32'(rxReady), 32'd1);
        check("abort_wen",     32'(wEn),     32'd0);
        check("abort_waddr",   32'(wAddr),   32'd0);
        check("abort_wdata",   32'(wData),   32'd0);
        check("abort_hold",    32'(cpuHold), 32'd1);
        check("abort_done",    32'(done),    32'd0);
        check("abort_error",   32'(error),   32'd0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_write", 32'(wrDataQ.size()), 32'd0);
        for (int j = 0; j < int'(vecs[0].len); j++) sendByte(vecs[0].bytes[j], 0);
        idle(int'(vecs[0].settle));
        check("reload_done", 32'(done), 32'd1);
        checkWrites("reload", 2, 18'h12345, 18'h3FFFF);

        // Random frames with gaps, garbage, bad headers and corrupted checksums.
        doReset();
        streamQ.delete();
        for (int f = 0; f < 16; f++) begin
            logic [7:0] frameQ[$];
            logic [7:0] cs;
            logic [7:0] b;
            int         n;
            int         g;
            g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) begin
                b = 8'($urandom_range(0, 255));
                frameQ.push_back((b == SYNC_BYTE) ? 8'h00 : b);
            end
            n = $urandom_range(0, 4);
            frameQ.push_back(SYNC_BYTE);
            frameQ.push_back(8'h00);
            frameQ.push_back(8'(n));
            cs = 8'(n);
            for (int w = 0; w < n; w++) begin
                for (int k = 0; k < 3; k++) begin
                    if (k == 0) b = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255))
                                                                 : 8'($urandom_range(0, 3));
                    else        b = 8'($urandom_range(0, 255));
                    frameQ.push_back(b);
                    cs ^= b;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            if ($urandom_range(0, 3) == 0) cs ^= 8'($urandom_range(1, 255));
            frameQ.push_back(cs);
`endif
            foreach (frameQ[k]) begin
                sendByte(frameQ[k], ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2)) : 0);
                streamQ.push_back(frameQ[k]);
            end
            idle(3);
            runModel();
            check($sformatf("rnd%0d_done", f),  32'(done),    32'(expStatus == 1));
            check($sformatf("rnd%0d_error", f), 32'(error),   32'(expStatus == 2));
            check($sformatf("rnd%0d_hold", f),  32'(cpuHold), 32'(expStatus != 1));
            check($sformatf("rnd%0d_nwrites", f), 32'(wrDataQ.size()), 32'(expDataQ.size()));
        end
        for (int k = 0; k < expDataQ.size() && k < wrDataQ.size(); k++) begin
            check($sformatf("rnd_waddr%0d", k), 32'(wrAddrQ[k]), 32'(expAddrQ[k]));
            check($sformatf("rnd_wdata%0d", k), 32'(wrDataQ[k]), 32'(expDataQ[k]));
        end

        check("ready_low_only_in_write", 32'(readyBad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
